// File: rtl/reprog_pkg.sv
// reprog_pkg: shared constants and FSM state type for the reprogram memory writer.
package reprog_pkg;
    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;
    localparam logic [22:0] INIT_ADDR = 23'h7FFFFF;
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
endpackage

// File: rtl/reprog_fifo.sv
// reprog_fifo: synchronous fall-through FIFO; DEPTH must be a power of two.
module reprog_fifo #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 4
) (
    input  logic                     clk_50mhz,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_count;
    logic             w_rd;
    logic             w_wr;
    assign w_rd  = pop && !empty;
    // a pop on the same edge frees the slot a full FIFO needs
    assign w_wr  = push && (!full || w_rd);
    assign full  = r_count[AW];
    assign empty = r_count == '0;
    assign count = r_count;
    assign dout  = r_mem[r_rp];
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_wp    <= w_wr ? r_wp + 1'b1 : r_wp;
            r_rp    <= w_rd ? r_rp + 1'b1 : r_rp;
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
        end
    end
    always_ff @(posedge clk_50mhz) begin
        if (w_wr) r_mem[r_wp] <= din;
    end
endmodule

// File: rtl/reprog_mem_writer.sv
// reprog_mem_writer: turns address changes from the UART reprogram stage into
// buffered four-phase memory writes, with write count and running checksum.
module reprog_mem_writer
    import reprog_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_50mhz,
    input  logic              rst,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic              busy,
    output logic              overflow,
    output logic [ADDR_W-1:0] words_written,
    output logic [DATA_W-1:0] sum
);
    localparam logic [ADDR_W-1:0] L_INIT = ADDR_W'(INIT_ADDR);
    state_t                       r_state;
    state_t                       w_state_nx;
    logic [ADDR_W-1:0]            r_last_addr;
    logic                         w_detect;
    logic                         w_pop;
    logic                         w_done;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_count;
    logic [ADDR_W+DATA_W-1:0]     w_head;
    assign w_detect = in_write && (in_addr != r_last_addr);
    assign busy     = (w_count != '0) || (r_state != IDLE);
    reprog_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .push      (w_detect),
        .pop       (w_pop),
        .din       ({in_addr, in_data}),
        .dout      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );
    // IDLE also waits for mem_ack low so a stale ack never starts a request
    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE: if (!w_empty && !mem_ack) begin
                w_pop      = 1'b1;
                w_state_nx = REQ;
            end
            REQ: if (mem_ack) begin
                w_done     = 1'b1;
                w_state_nx = RELEASE;
            end
            RELEASE: if (!mem_ack) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_50mhz) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            overflow      <= 1'b0;
            words_written <= '0;
            sum           <= '0;
            r_last_addr   <= L_INIT;
        end else begin
            // an undetected word already equals r_last_addr, so loading in_addr is safe
            r_last_addr <= in_write ? in_addr : L_INIT;
            if (w_detect && w_full && !w_pop) overflow <= 1'b1;
            if (w_pop) begin
                mem_req   <= 1'b1;
                mem_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
                mem_wdata <= w_head[DATA_W-1:0];
            end
            if (w_done) begin
                mem_req       <= 1'b0;
                words_written <= words_written + 1'b1;
                sum           <= sum + mem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_reprog_mem_writer.sv
// tb_reprog_mem_writer: directed scenarios with a request scoreboard that
// checks every memory request against the words the bench expects to land.
module tb_reprog_mem_writer;
    logic        clk_50mhz = 1'b0;
    logic        rst;
    logic [22:0] in_addr;
    logic [31:0] in_data;
    logic        in_write;
    logic [22:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_ack;
    logic        busy;
    logic        overflow;
    logic [22:0] words_written;
    logic [31:0] sum;
    int          n_tot = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [54:0] exp_q[$];
    logic        prev_req = 1'b0;

    reprog_mem_writer dut (
        .clk_50mhz     (clk_50mhz),
        .rst           (rst),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_write      (in_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .busy          (busy),
        .overflow      (overflow),
        .words_written (words_written),
        .sum           (sum)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50mhz);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_write = 1'b0;
        in_addr = 23'h7FFFFF;
        in_data = '0;
        mem_ack = 1'b0;
        cyc(2);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic word(input logic [22:0] a, input logic [31:0] d, input bit expect_it);
        in_write = 1'b1;
        in_addr = a;
        in_data = d;
        if (expect_it) exp_q.push_back({a, d});
        cyc(1);
    endtask

    task automatic ack_one(input int hold);
        for (int i = 0; i < 40 && !mem_req; i++) cyc(1);
        chk("req_wait", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        cyc(1);
        chk("req_drop", 64'(mem_req), 64'd0);
        repeat (hold - 1) cyc(1);
        mem_ack = 1'b0;
        cyc(1);
    endtask

    // scoreboard: every rising mem_req must match the oldest expected word
    always @(negedge clk_50mhz) begin
        logic [54:0] e;
        if (mem_req && !prev_req) begin
            n_tot++;
            assert (exp_q.size() > 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("req_addr", 64'(mem_addr), 64'(e[54:32]));
                chk("req_data", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
        prev_req = mem_req;
    end

    initial begin
        logic [31:0] s;
        do_reset();
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ww", 64'(words_written), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);

        // single word, ack after 3 cycles
        word(23'h0, 32'hDEADBEEF, 1'b1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_latency_low", 64'(mem_req), 64'd0);
        cyc(1);
        chk("t1_latency_high", 64'(mem_req), 64'd1);
        cyc(3);
        chk("t1_hold", 64'(mem_req), 64'd1);
        ack_one(1);
        chk("t1_ww", 64'(words_written), 64'd1);
        chk("t1_sum", 64'(sum), 64'hDEADBEEF);
        cyc(1);
        chk("t1_idle", 64'(busy), 64'd0);

        // session restart: 0,1, in_write low 2 cycles, 0 again
        do_reset();
        word(23'h0, 32'h1, 1'b1);
        word(23'h1, 32'h2, 1'b1);
        in_write = 1'b0;
        cyc(2);
        word(23'h0, 32'h11111111, 1'b1);
        repeat (3) ack_one(1);
        chk("t4_ww", 64'(words_written), 64'd3);
        chk("t4_sum", 64'(sum), 64'h11111114);

        // burst with ack stuck low: word 5 is dropped
        do_reset();
        s = '0;
        for (int a = 0; a < 6; a++) begin
            if (a < 5) s += 32'hA000 + 32'(a);
            word(23'(a), 32'hA000 + 32'(a), a < 5);
        end
        chk("t2_ovf", 64'(overflow), 64'd1);
        repeat (5) ack_one(1);
        chk("t2_ww", 64'(words_written), 64'd5);
        chk("t2_sum", 64'(sum), 64'(s));
        chk("t2_ovf_sticky", 64'(overflow), 64'd1);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // full FIFO: push coincides with pop
        do_reset();
        for (int a = 20; a < 25; a++) word(23'(a), 32'hB0 + 32'(a), 1'b1);
        mem_ack = 1'b1;
        cyc(1);
        mem_ack = 1'b0;
        cyc(1);
        word(23'd25, 32'hB0 + 32'd25, 1'b1);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_req", 64'(mem_req), 64'd1);
        repeat (5) ack_one(1);
        chk("t6_ww", 64'(words_written), 64'd6);
        chk("t6_ovf_end", 64'(overflow), 64'd0);

        // ack held high 5 cycles with a word waiting
        do_reset();
        word(23'd30, 32'hC30, 1'b1);
        word(23'd31, 32'hC31, 1'b1);
        mem_ack = 1'b1;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("t5_ack_high", 64'(mem_req), 64'd0);
        end
        mem_ack = 1'b0;
        cyc(1);
        chk("t5_release", 64'(mem_req), 64'd0);
        cyc(1);
        chk("t5_reissue", 64'(mem_req), 64'd1);
        ack_one(1);
        chk("t5_ww", 64'(words_written), 64'd2);

        // reset mid-REQ with 2 words buffered
        do_reset();
        word(23'd9, 32'h9, 1'b1);
        ack_one(1);
        word(23'd10, 32'h10, 1'b1);
        word(23'd11, 32'h11, 1'b0);
        word(23'd12, 32'h12, 1'b0);
        chk("t3_req", 64'(mem_req), 64'd1);
        rst = 1'b1;
        in_write = 1'b0;
        cyc(1);
        chk("t3_req_drop", 64'(mem_req), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_ww", 64'(words_written), 64'd0);
        chk("t3_sum", 64'(sum), 64'd0);
        rst = 1'b0;
        cyc(8);
        chk("t3_quiet", 64'(mem_req), 64'd0);
        chk("t3_quiet_busy", 64'(busy), 64'd0);

        // first request after reset waits for ack low
        mem_ack = 1'b1;
        word(23'd40, 32'h40, 1'b1);
        cyc(3);
        chk("t7_wait_ack", 64'(mem_req), 64'd0);
        mem_ack = 1'b0;
        cyc(1);
        chk("t7_req", 64'(mem_req), 64'd1);
        ack_one(1);
        chk("t7_ww", 64'(words_written), 64'd1);
        chk("t7_sum", 64'(sum), 64'h40);
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
